bus_uart_tx: RTL and testbench
==============================

# bus_uart_tx

Memory-mapped UART transmitter that sits on the core's data bus as a responder. It decodes the core's `bus_address`/`bus_read`/`bus_write` strobes, returns read data in the same cycle so the single-cycle core needs no wait states, and buffers written bytes in a FIFO. A baud-rate serializer shifts those bytes out on a single `tx` line.

## Interface
- `BASE_ADDR`, default 32'h1000_0000: base address of the 16-byte register window; bits [3:0] must be 0.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two, at least 2.
- `DEFAULT_DIV`, default 16'd868: reset value of DIVISOR, in clock cycles per bit.

Ports:
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `bus_address` input 32: byte address from the core.
- `bus_write_data` input 32: store data from the core.
- `bus_read_data` output 32: combinational read data.
- `bus_write` input 1: store strobe, valid for one cycle per store.
- `bus_read` input 1: load strobe.
- `tx` output 1: serial line; idles high.
- `tx_idle` output 1: high when the FIFO is empty and the serializer is in IDLE.

## Operation
- Select: `bus_address[31:4] == BASE_ADDR[31:4]`. Register offset is `bus_address[3:2]`; `bus_address[1:0]` is ignored.
- Unselected accesses:
  - Writes are ignored.
  - `bus_read_data` = 0.
- Register map:
  - 0x0 TXDATA (write-only): a write pushes `bus_write_data[7:0]`. A write while full drops the byte and sets sticky OVF. Reads return 0.
  - 0x4 STATUS: read = {16'b0, level[7:0], 4'b0, OVF, busy, full, empty}.
    - `level` is the FIFO occupancy, 0..FIFO_DEPTH.
    - A write with `bus_write_data[3]`=1 clears OVF; other bits are ignored.
  - 0x8 DIVISOR: read/write, bits [15:0]; upper bits read 0. A value of 0 is treated as 1.
  - 0xC: reserved; reads 0, writes ignored.
- Reads have no side effects. When `bus_read` is low, `bus_read_data` still reflects the decoded register.
- Serializer FSM (`busy` = state != IDLE):
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, latch DIVISOR, and go to START.
  - START: `tx`=0 for DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, DIV cycles each, then go to STOP (or PARITY when enabled).
  - STOP: `tx`=1 for DIV cycles, then go to IDLE.
- The baud counter loads DIV-1 on each bit entry and counts down; the bit ends when the counter reaches 0.
- DIVISOR writes mid-frame take effect at the next frame only.
- Simultaneous push and pop: push is checked against full *before* the pop. A push to a full FIFO in a pop cycle is therefore dropped with OVF set, and the level decrements.
- FIFO pointers wrap modulo FIFO_DEPTH. `level` is kept as a separate counter of width log2(FIFO_DEPTH)+1.

## Timing
- Reset values:
  - `tx`=1, `tx_idle`=1, state=IDLE.
  - FIFO empty: level=0, pointers=0.
  - OVF=0, DIVISOR=DEFAULT_DIV.
  - `bus_read_data` is combinational: 0 for unselected addresses, register contents otherwise.
- Reset asserted mid-frame: `tx` returns to 1 at the next edge, the frame is aborted, and FIFO contents are discarded.
- Write to TXDATA at edge N while IDLE and empty:
  - level=1 after N.
  - Pop at N+1; START entered and `tx` falls after N+1.
  - Frame = 10×DIV cycles (11×DIV with parity), then one IDLE cycle with `tx`=1.
  - The next pop occurs at the following edge, so back-to-back frames are separated by exactly 1 idle cycle.
- STATUS read in the same cycle as a TXDATA write returns the pre-write state.

## Configuration
- `BUS_UART_TX_PARITY_EN`:
  - Defined: adds a PARITY state between DATA and STOP. It drives the even parity of the data byte for DIV cycles. Frame = 11×DIV.
  - Undefined: no PARITY state. Frame = 10×DIV.

## Test plan
- Reset values: hold `reset`=0 for 2 cycles, then read STATUS -> 0x0000_0001; read DIVISOR -> 868; `tx`=1, `tx_idle`=1.
- Single byte: write DIVISOR=4, then TXDATA=0x55 -> `tx` low 4 cycles starting 1 edge after the write, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop high 4 cycles; `tx_idle` rises after the idle cycle; total 40 cycles of frame.
- Overflow: DIVISOR=100, write 10 bytes 0x00..0x09 on consecutive cycles -> first byte popped, 8 buffered, 10th dropped; STATUS reads level=8, full=1, OVF=1. Write STATUS with bit3=1 -> OVF=0. Received bytes are 0x00..0x08 only.
- Decode: read 0x1000_0010 and 0x1000_000C -> 0. Write 0x1000_0010 -> no FIFO change. Byte address 0x1000_0009 reads DIVISOR. DIVISOR=0 -> 1 cycle per bit.
- Mid-frame: change DIVISOR from 4 to 8 during byte 1 of two queued bytes -> byte 1 uses 4 cycles per bit, byte 2 uses 8. Assert `reset` during the data bits -> `tx`=1 next cycle, level=0.
- Parity (macro defined): DIVISOR=2, TXDATA=0x07 -> parity bit=1 for 2 cycles before stop; frame = 22 cycles.

Source files
------------

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped UART transmitter acting as a bus responder.
// Register window (16 bytes at BASE_ADDR): TXDATA, STATUS, DIVISOR, reserved.
// Written bytes are queued in a TX FIFO and shifted out 8N1, LSB first.
// Optional build macro BUS_UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module bus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    input  logic        bus_write,
    input  logic        bus_read,
    output logic        tx,
    output logic        tx_idle
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // Registers
    state_t             state_r;
    logic [15:0]        cnt_r;
    logic [2:0]         bit_idx_r;
    logic [7:0]         data_r;
    logic [15:0]        div_lat_r;
    logic               tx_r;
    logic [15:0]        divisor_r;
    logic               ovf_r;
    logic [LVL_W-1:0]   level_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [7:0]         fifo_mem_r [FIFO_DEPTH];

    // Next-state and decode signals
    state_t             state_next_s;
    logic [15:0]        cnt_next_s;
    logic [2:0]         bit_idx_next_s;
    logic [7:0]         data_next_s;
    logic [15:0]        div_lat_next_s;
    logic               tx_next_s;
    logic               sel_s;
    logic [1:0]         offset_s;
    logic               wr_txdata_s;
    logic               wr_status_s;
    logic               wr_div_s;
    logic               empty_s;
    logic               full_s;
    logic               busy_s;
    logic               push_s;
    logic               drop_s;
    logic               pop_s;
    logic [15:0]        div_eff_s;
    logic [31:0]        level_ext_s;
    logic [31:0]        status_s;
    logic [31:0]        rd_data_s;
    logic               unused_s;

    assign sel_s       = (bus_address[31:4] == BASE_ADDR[31:4]);
    assign offset_s    = bus_address[3:2];
    assign wr_txdata_s = sel_s & bus_write & (offset_s == 2'd0);
    assign wr_status_s = sel_s & bus_write & (offset_s == 2'd1);
    assign wr_div_s    = sel_s & bus_write & (offset_s == 2'd2);
    assign empty_s     = (level_r == LVL_W'(0));
    assign full_s      = (level_r == LVL_W'(FIFO_DEPTH));
    assign busy_s      = (state_r != ST_IDLE);
    // Push is qualified against full before any same-cycle pop frees a slot.
    assign push_s      = wr_txdata_s & ~full_s;
    assign drop_s      = wr_txdata_s & full_s;
    assign pop_s       = (state_r == ST_IDLE) & ~empty_s;
    assign div_eff_s   = (divisor_r == 16'd0) ? 16'd1 : divisor_r;
    assign level_ext_s = 32'(level_r);
    assign status_s    = {16'd0, level_ext_s[7:0], 4'd0, ovf_r, busy_s, full_s, empty_s};
    assign unused_s    = ^{bus_read, bus_address[1:0], bus_write_data[31:16]};

    assign bus_read_data = rd_data_s;
    assign tx            = tx_r;
    assign tx_idle       = empty_s & (state_r == ST_IDLE);

    // Read mux: side-effect free, independent of bus_read.
    always_comb begin
        rd_data_s = 32'd0;
        if (sel_s) begin
            case (offset_s)
                2'd1:    rd_data_s = status_s;
                2'd2:    rd_data_s = {16'd0, divisor_r};
                default: rd_data_s = 32'd0;
            endcase
        end else begin
            rd_data_s = 32'd0;
        end
    end

    // Serializer next-state, baud counter and next tx level.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        bit_idx_next_s = bit_idx_r;
        data_next_s    = data_r;
        div_lat_next_s = div_lat_r;
        tx_next_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_next_s   = ST_START;
                    data_next_s    = fifo_mem_r[rd_ptr_r];
                    div_lat_next_s = div_eff_s;
                    cnt_next_s     = div_eff_s - 16'd1;
                    bit_idx_next_s = 3'd0;
                    tx_next_s      = 1'b0;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_r == 16'd0) begin
                    state_next_s   = ST_DATA;
                    cnt_next_s     = div_lat_r - 16'd1;
                    bit_idx_next_s = 3'd0;
                    tx_next_s      = data_r[0];
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                    tx_next_s  = 1'b0;
                end
            end
            ST_DATA: begin
                if (cnt_r == 16'd0) begin
                    cnt_next_s = div_lat_r - 16'd1;
                    if (bit_idx_r == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
                        state_next_s = ST_PARITY;
                        tx_next_s    = even_parity(data_r);
`else
                        state_next_s = ST_STOP;
                        tx_next_s    = 1'b1;
`endif
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                        tx_next_s      = data_r[bit_idx_r + 3'd1];
                    end
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                    tx_next_s  = data_r[bit_idx_r];
                end
            end
`ifdef BUS_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == 16'd0) begin
                    state_next_s = ST_STOP;
                    cnt_next_s   = div_lat_r - 16'd1;
                    tx_next_s    = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                    tx_next_s  = even_parity(data_r);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r == 16'd0) begin
                    state_next_s = ST_IDLE;
                    tx_next_s    = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                    tx_next_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                tx_next_s    = 1'b1;
            end
        endcase
    end

    // Serializer state register; reset aborts any frame and idles the line.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            data_r    <= 8'd0;
            div_lat_r <= 16'd1;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            bit_idx_r <= bit_idx_next_s;
            data_r    <= data_next_s;
            div_lat_r <= div_lat_next_s;
            tx_r      <= tx_next_s;
        end
    end

    // FIFO bookkeeping plus the STATUS/DIVISOR control registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            level_r   <= LVL_W'(0);
            wr_ptr_r  <= PTR_W'(0);
            rd_ptr_r  <= PTR_W'(0);
            ovf_r     <= 1'b0;
            divisor_r <= DEFAULT_DIV;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (wr_status_s && bus_write_data[3]) begin
                ovf_r <= 1'b0;
            end
            if (wr_div_s) divisor_r <= bus_write_data[15:0];
        end
    end

    // FIFO storage; contents are don't-care until pointed at by a push.
    always_ff @(posedge clock) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= bus_write_data[7:0];
    end
endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx. A behavioural reference builds the
// expected serial frame from the byte and divisor; a line monitor records tx
// per cycle and a frame decoder recovers bytes, start positions and stop bits.
module tb_bus_uart_tx;
`ifdef BUS_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam logic [31:0] A_TX   = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;
    localparam logic [31:0] A_DIV  = 32'h1000_0008;
    localparam logic [31:0] A_RSV  = 32'h1000_000C;

    logic        clock;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_write;
    logic        bus_read;
    logic        tx;
    logic        tx_idle;

    int tests = 0;
    int fails = 0;

    logic       trace_on = 1'b0;
    logic       trace_q[$];
    int         rx_divs[$];
    logic [7:0] rx_bytes[$];
    int         rx_starts[$];
    logic       rx_stops[$];
    logic       rx_pars[$];

    bus_uart_tx dut (
        .clock          (clock),
        .reset          (reset),
        .bus_address    (bus_address),
        .bus_write_data (bus_write_data),
        .bus_read_data  (bus_read_data),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .tx             (tx),
        .tx_idle        (tx_idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Line monitor, sampling well after the edge and after stimulus updates.
    always @(posedge clock) begin
        #2;
        if (trace_on) trace_q.push_back(tx);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        bus_address    = addr;
        bus_write_data = data;
        bus_write      = 1'b1;
        tick();
        bus_write      = 1'b0;
        bus_address    = 32'h0;
        bus_write_data = 32'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_address = addr;
        bus_read    = 1'b1;
        #1;
        chk(tag, bus_read_data, exp);
        bus_read    = 1'b0;
        bus_address = 32'h0;
    endtask

    // Reference: line level in frame slot (start, data LSB first, [parity], stop).
    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0)                     return 1'b0;
        else if (slot <= 8)                return b[slot-1];
        else if (NBITS == 11 && slot == 9) return ^b;
        else                               return 1'b1;
    endfunction

    // Called right after the TXDATA write edge with FIFO empty and line idle.
    task automatic expect_frame(input logic [7:0] b, input int d, input string tag);
        for (int i = 0; i < NBITS * d; i++) begin
            tick();
            chk(tag, {31'd0, tx}, {31'd0, frame_bit(b, i / d)});
            if (i == 0) chk({tag, "_busy_idle"}, {31'd0, tx_idle}, 32'd0);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (tx_idle !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, tx_idle}, 32'd1);
        tick();
        tick();
    endtask

    // Decode recorded line into frames, one divisor per expected frame.
    task automatic decode_trace();
        int pos = 0;
        int d;
        logic [7:0] b;
        rx_bytes.delete(); rx_starts.delete(); rx_stops.delete(); rx_pars.delete();
        for (int f = 0; f < rx_divs.size(); f++) begin
            d = rx_divs[f];
            while (pos < trace_q.size() && trace_q[pos] !== 1'b0) pos++;
            if (pos + NBITS * d > trace_q.size()) break;
            for (int k = 0; k < 8; k++) b[k] = trace_q[pos + d/2 + (k+1)*d];
            rx_bytes.push_back(b);
            rx_starts.push_back(pos);
            rx_stops.push_back(trace_q[pos + d/2 + (NBITS-1)*d]);
            if (NBITS == 11) rx_pars.push_back(trace_q[pos + d/2 + 9*d]);
            pos += NBITS * d;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] b2;
        logic [7:0] sent[$];
        int d;
        int n;

        reset = 1'b0; bus_address = 32'h0; bus_write_data = 32'h0;
        bus_write = 1'b0; bus_read = 1'b0;

        // Reset values
        tick(); tick();
        reset = 1'b1;
        rd_chk("rst_status", A_STAT, 32'h0000_0001);
        rd_chk("rst_div", A_DIV, 32'd868);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_tx_idle", {31'd0, tx_idle}, 32'd1);

        // Single byte, DIV=4
        bus_wr(A_DIV, 32'd4);
        bus_wr(A_TX, 32'h55);
        rd_chk("single_level1", A_STAT, 32'h0000_0100);
        expect_frame(8'h55, 4, "single_tx");
        tick();
        chk("single_idle_tx", {31'd0, tx}, 32'd1);
        tick();
        chk("single_tx_idle", {31'd0, tx_idle}, 32'd1);
        rd_chk("single_status_end", A_STAT, 32'h0000_0001);

        // Decode and DIVISOR=0
        rd_chk("dec_0x10", 32'h1000_0010, 32'h0);
        rd_chk("dec_rsv", A_RSV, 32'h0);
        rd_chk("dec_txdata_rd", A_TX, 32'h0);
        rd_chk("dec_other", 32'h2000_0004, 32'h0);
        bus_wr(32'h1000_0010, 32'h41);
        rd_chk("dec_unsel_wr", A_STAT, 32'h0000_0001);
        bus_wr(A_RSV, 32'h41);
        rd_chk("dec_rsv_wr", A_STAT, 32'h0000_0001);
        bus_wr(A_DIV, 32'hFFFF_0005);
        rd_chk("dec_byte_addr", 32'h1000_0009, 32'd5);
        bus_wr(A_DIV, 32'd0);
        rd_chk("dec_div0_rd", A_DIV, 32'd0);
        b = 8'($urandom);
        bus_wr(A_TX, {24'd0, b});
        expect_frame(b, 1, "div0_tx");
        tick();
        chk("div0_idle_tx", {31'd0, tx}, 32'd1);

        // Overflow, DIV=100
        bus_wr(A_DIV, 32'd100);
        trace_q.delete();
        trace_on = 1'b1;
        for (int v = 0; v < 10; v++) bus_wr(A_TX, v);
        rd_chk("ovf_status", A_STAT, 32'h0000_080E);
        bus_wr(A_STAT, 32'h8);
        rd_chk("ovf_clear", A_STAT, 32'h0000_0806);
        wait_idle(12000, "ovf_timeout");
        trace_on = 1'b0;
        rx_divs.delete();
        for (int v = 0; v < 10; v++) rx_divs.push_back(100);
        decode_trace();
        chk("ovf_count", rx_bytes.size(), 32'd9);
        for (int v = 0; v < rx_bytes.size() && v < 9; v++)
            chk("ovf_byte", {24'd0, rx_bytes[v]}, v);

        // Mid-frame divisor change
        bus_wr(A_DIV, 32'd4);
        b = 8'($urandom); b2 = 8'($urandom);
        trace_q.delete();
        trace_on = 1'b1;
        bus_wr(A_TX, {24'd0, b});
        bus_wr(A_TX, {24'd0, b2});
        for (int i = 0; i < 5; i++) tick();
        bus_wr(A_DIV, 32'd8);
        wait_idle(500, "mid_timeout");
        trace_on = 1'b0;
        rx_divs.delete(); rx_divs.push_back(4); rx_divs.push_back(8);
        decode_trace();
        chk("mid_count", rx_bytes.size(), 32'd2);
        if (rx_bytes.size() == 2) begin
            chk("mid_byte1", {24'd0, rx_bytes[0]}, {24'd0, b});
            chk("mid_byte2", {24'd0, rx_bytes[1]}, {24'd0, b2});
            chk("mid_spacing", rx_starts[1] - rx_starts[0], NBITS * 4 + 1);
            chk("mid_stop2", {31'd0, rx_stops[1]}, 32'd1);
        end

        // Reset asserted during data bits
        bus_wr(A_DIV, 32'd4);
        bus_wr(A_TX, 32'h00);
        bus_wr(A_TX, 32'h00);
        for (int i = 0; i < 6; i++) tick();
        chk("rstmid_data_low", {31'd0, tx}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rstmid_tx", {31'd0, tx}, 32'd1);
        rd_chk("rstmid_status", A_STAT, 32'h0000_0001);
        reset = 1'b1;
        tick(); tick();
        chk("rstmid_tx_after", {31'd0, tx}, 32'd1);
        chk("rstmid_tx_idle", {31'd0, tx_idle}, 32'd1);

        // Randomized bursts against the frame reference
        for (int r = 0; r < 4; r++) begin
            d = $urandom_range(6, 1);
            n = $urandom_range(4, 1);
            bus_wr(A_DIV, d);
            sent.delete();
            trace_q.delete();
            trace_on = 1'b1;
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                sent.push_back(b);
                bus_wr(A_TX, {24'd0, b});
            end
            wait_idle(400, "rnd_timeout");
            trace_on = 1'b0;
            rx_divs.delete();
            for (int k = 0; k < n; k++) rx_divs.push_back(d);
            decode_trace();
            chk("rnd_count", rx_bytes.size(), n);
            for (int k = 0; k < n && k < rx_bytes.size(); k++) begin
                chk("rnd_byte", {24'd0, rx_bytes[k]}, {24'd0, sent[k]});
                chk("rnd_stop", {31'd0, rx_stops[k]}, 32'd1);
`ifdef BUS_UART_TX_PARITY_EN
                chk("rnd_parity", {31'd0, rx_pars[k]}, {31'd0, ^sent[k]});
`endif
                if (k > 0) chk("rnd_spacing", rx_starts[k] - rx_starts[k-1], NBITS * d + 1);
            end
        end

`ifdef BUS_UART_TX_PARITY_EN
        // Parity frame: DIV=2, 0x07 -> parity 1, 22-cycle frame
        bus_wr(A_DIV, 32'd2);
        bus_wr(A_TX, 32'h07);
        expect_frame(8'h07, 2, "par_tx");
        tick();
        chk("par_idle_tx", {31'd0, tx}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
